clk_div_scheduler: RTL and testbench
====================================

// Module: clk_div_scheduler
// PURPOSE
//  Runtime-programmable clock-divider controller: NUM_CH independent channels derived from CLK100MHZ.
//  Each channel emits a square wave and a 1-cycle tick enable.
//  A single-slot config handshake schedules divisor/enable changes to take effect only at a period
//  boundary, so divided clocks never glitch. Feeds LED/PMOD drivers and downstream clock-enable logic.
// PARAMETERS
//  NUM_CH       4        number of divider channels
//  CNT_W        27       counter/divisor width (covers 1 Hz from 100 MHz)
//  DEFAULT_DIV  100_000  divisor loaded at reset (1 kHz)
// PORTS
//  CLK100MHZ   in   1               system clock, 100 MHz; all logic on its rising edge
//  RST         in   1               asynchronous, active-high reset
//  cfg_valid   in   1               config request
//  cfg_ready   out  1               config slot free; transfer when cfg_valid && cfg_ready
//  cfg_ch      in   $clog2(NUM_CH)  target channel
//  cfg_div     in   CNT_W           new divisor (period in CLK100MHZ cycles)
//  cfg_en      in   1               new channel enable
//  ch_clk      out  NUM_CH          divided square wave per channel (registered)
//  ch_tick     out  NUM_CH          1-cycle pulse on last cycle of each period (registered)
//  ch_active   out  NUM_CH          channel currently running
// BEHAVIOUR
//  Reset:
//   - All ctr=0, div=DEFAULT_DIV, en=0.
//   - ch_clk=0, ch_tick=0, ch_active=0, cfg_ready=1, FSM=IDLE.
//   - Reset mid-operation discards any pending config.
//  Channel counting (en=1):
//   - ctr counts 0..div-1, then wraps to 0.
//   - ch_clk=1 while ctr < ceil(div/2), else 0.
//   - ch_tick=1 when ctr==div-1.
//   - Outputs are registered and reflect the ctr value of the same cycle.
//  Divisor clamp:
//   - cfg_div of 0 or 1 is stored as 2, the minimum (50 MHz).
//   - Odd div gives a high phase one cycle longer than the low phase.
//  Disabled channel: ctr held at 0; ch_clk=0, ch_tick=0, ch_active=0.
//  Config FSM (one shared pending slot):
//   - IDLE: cfg_ready=1.
//     - On transfer: capture ch/div/en into the pending slot, cfg_ready=0 next cycle, go to PENDING.
//   - PENDING: wait for the apply point.
//     - Target disabled: apply point is the next cycle.
//     - Target enabled: apply point is the cycle its ctr==div-1; the current period always completes
//       with the old div.
//   - APPLY (1 cycle): load div/en, set target ctr=0, go to IDLE. cfg_ready=1 the following cycle.
//  Enable/disable timing:
//   - Enable of an idle channel: first ch_clk high at APPLY+1.
//   - Disable: takes effect after the final full period; no runt pulse.
//  Latency: disabled target gives cfg_ready low for 2 cycles; enabled target waits up to div+1 cycles.
//  Simultaneous events:
//   - Transfer in the same cycle as APPLY is impossible, because cfg_ready=0.
//   - Wrap and apply in the same cycle: the tick still fires for the completed period.
// CONFIGURATION
//  PHASE_SYNC_EN defined:
//   - Adds input sync_req (1 bit).
//   - sync_req=1 forces ctr=0 on every enabled channel next cycle, realigning all phases.
//   - A PENDING config is applied in that same cycle, regardless of wrap position.
//   - sync_req held high keeps channels at ctr=0: ch_clk=1, no ticks.
//  PHASE_SYNC_EN undefined: no sync_req port; channels free-run independently.
// TESTING
//  1. RST pulse mid-run -> all outputs 0 and cfg_ready=1 asynchronously; PENDING slot cleared.
//  2. cfg ch0 div=2 en=1 -> ch_clk[0] toggles every cycle (50 MHz); ch_tick[0] every 2nd cycle.
//  3. cfg ch1 div=100_000 en=1 -> ch_tick[1] period 100_000 cycles; ch_clk[1] high 50_000 cycles.
//  4. ch2 running div=10; write div=4 at ctr=3 -> cfg_ready low until ctr==9 wrap; next periods = 4.
//  5. cfg_div=0 and cfg_div=1 -> both behave as div=2.
//     Disable ch0 mid-period -> period completes, then ch_clk[0]=0 and ch_active[0]=0.
//  6. (PHASE_SYNC_EN) ch0 div=6, ch1 div=3 running; pulse sync_req -> both ctr=0 next cycle;
//     rising edges coincide.

Source files
------------

// File: rtl/clk_div_scheduler_if.sv
// clk_div_scheduler_if
//   Config handshake and per-channel divider outputs for clk_div_scheduler.
//   master : drives cfg_valid/cfg_ch/cfg_div/cfg_en, observes cfg_ready and channel outputs
//   slave  : the scheduler itself
//   cfg_valid/cfg_ready : single-slot config transfer (both high on a rising edge)
//   cfg_ch/cfg_div/cfg_en : target channel, divisor (period in cycles), enable
//   ch_clk/ch_tick/ch_active : per-channel square wave, end-of-period pulse, running flag
interface clk_div_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 27
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic                cfg_en;
    logic [NUM_CH-1:0]   ch_clk;
    logic [NUM_CH-1:0]   ch_tick;
    logic [NUM_CH-1:0]   ch_active;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready, ch_clk, ch_tick, ch_active
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready, ch_clk, ch_tick, ch_active
    );
endinterface

// File: rtl/clk_div_scheduler.sv
// clk_div_scheduler
//   NUM_CH runtime-programmable clock dividers off CLK100MHZ. Each channel produces a
//   registered square wave (ch_clk), an end-of-period pulse (ch_tick) and a running flag
//   (ch_active). Divisor/enable updates go through one shared pending slot and are only
//   applied on a period boundary, so a divided clock never produces a runt pulse.
// Ports
//   CLK100MHZ : system clock, all logic on rising edge
//   RST       : asynchronous active-high reset
//   sync_req  : (PHASE_SYNC_EN only) restart all enabled channels at ctr=0
//   bus       : clk_div_scheduler_if.slave (config handshake + channel outputs)
// Build option
//   PHASE_SYNC_EN : adds sync_req phase realignment; undefined -> channels free-run.

// One divider channel. Outputs are registered from the next-state counter so that they
// describe the same cycle the counter value belongs to.
module clk_div_lane #(
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 100_000
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             apply,
    input  logic [CNT_W-1:0] ap_div,
    input  logic             ap_en,
    input  logic             sync,
    output logic             en,
    output logic             near_wrap,
    output logic             ch_clk,
    output logic             ch_tick,
    output logic             ch_active
);
    logic [CNT_W-1:0] ctr, div;
    logic [CNT_W-1:0] ctr_n, div_n;
    logic             en_n;
    logic [CNT_W:0]   half_n;

    // Next cycle is the last of the period; the scheduler uses this to land APPLY on it.
    assign near_wrap = en && (ctr == div - CNT_W'(2));

    always_comb begin
        div_n = div;
        en_n  = en;
        ctr_n = ctr + CNT_W'(1);
        if (apply) begin
            div_n = ap_div;
            en_n  = ap_en;
            ctr_n = '0;
        end else if (!en || sync || ctr == div - CNT_W'(1)) begin
            ctr_n = '0;
        end
    end

    // ceil(div/2): odd divisors get the extra cycle in the high phase
    assign half_n = ({1'b0, div_n} + 1'b1) >> 1;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            ctr       <= '0;
            div       <= CNT_W'(DEFAULT_DIV);
            en        <= 1'b0;
            ch_clk    <= 1'b0;
            ch_tick   <= 1'b0;
            ch_active <= 1'b0;
        end else begin
            ctr       <= ctr_n;
            div       <= div_n;
            en        <= en_n;
            ch_clk    <= en_n && ({1'b0, ctr_n} < half_n);
            ch_tick   <= en_n && (ctr_n == div_n - CNT_W'(1));
            ch_active <= en_n;
        end
    end
endmodule

module clk_div_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = 100_000
) (
    input  logic                  CLK100MHZ,
    input  logic                  RST,
`ifdef PHASE_SYNC_EN
    input  logic                  sync_req,
`endif
    clk_div_scheduler_if.slave    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   pend_ch;
    logic [CNT_W-1:0]  pend_div;
    logic              pend_en;
    logic              do_apply;
    logic              sync;
    logic [NUM_CH-1:0] lane_en, lane_near_wrap;
    logic [NUM_CH-1:0] clk_v, tick_v, act_v;

`ifdef PHASE_SYNC_EN
    assign sync = sync_req;
`else
    assign sync = 1'b0;
`endif

    assign bus.cfg_ready = (state == IDLE);
    assign bus.ch_clk    = clk_v;
    assign bus.ch_tick   = tick_v;
    assign bus.ch_active = act_v;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pend_ch  <= '0;
            pend_div <= CNT_W'(DEFAULT_DIV);
            pend_en  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.cfg_valid) begin
                pend_ch  <= bus.cfg_ch;
                pend_div <= (bus.cfg_div < CNT_W'(2)) ? CNT_W'(2) : bus.cfg_div;
                pend_en  <= bus.cfg_en;
            end
        end
    end

    always_comb begin
        state_n  = state;
        do_apply = 1'b0;
        case (state)
            IDLE:    if (bus.cfg_valid) state_n = PENDING;
            PENDING: begin
                // A sync restarts every period, so the slot can go in right away.
                if (sync) begin
                    do_apply = 1'b1;
                    state_n  = IDLE;
                end else if (!lane_en[pend_ch] || lane_near_wrap[pend_ch]) begin
                    state_n = APPLY;
                end
            end
            APPLY: begin
                do_apply = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        clk_div_lane #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_lane (
            .CLK100MHZ (CLK100MHZ),
            .RST       (RST),
            .apply     (do_apply && pend_ch == CH_W'(i)),
            .ap_div    (pend_div),
            .ap_en     (pend_en),
            .sync      (sync),
            .en        (lane_en[i]),
            .near_wrap (lane_near_wrap[i]),
            .ch_clk    (clk_v[i]),
            .ch_tick   (tick_v[i]),
            .ch_active (act_v[i])
        );
    end
endmodule

// File: tb/tb_clk_div_scheduler.sv
module tb_clk_div_scheduler;
    logic CLK100MHZ = 1'b0;
    logic RST       = 1'b1;
`ifdef PHASE_SYNC_EN
    logic sync_req  = 1'b0;
`endif

    always #5 CLK100MHZ = ~CLK100MHZ;

    clk_div_scheduler_if #(.NUM_CH(4), .CNT_W(27)) bus ();

    clk_div_scheduler #(.NUM_CH(4), .CNT_W(27), .DEFAULT_DIV(100_000)) dut (
        .CLK100MHZ (CLK100MHZ),
        .RST       (RST),
`ifdef PHASE_SYNC_EN
        .sync_req  (sync_req),
`endif
        .bus       (bus)
    );

    typedef struct { int per; int hi; } exp_t;

    exp_t exq [4][$];   // expected {period, high cycles} per channel, popped on each tick
    int   rq [$];       // expected cfg_ready low-run lengths
    int   checks = 0;
    int   errors = 0;
    int   cnt [4];
    int   hi  [4];
    int   lowrun = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: measures each period between ticks and each cfg_ready low run.
    always @(negedge CLK100MHZ) begin
        exp_t e;
        if (RST) begin
            for (int c = 0; c < 4; c++) begin cnt[c] = 0; hi[c] = 0; end
            lowrun = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (bus.ch_active[c]) begin
                    cnt[c]++;
                    if (bus.ch_clk[c]) hi[c]++;
                    if (bus.ch_tick[c]) begin
                        if (exq[c].size() > 0) begin
                            e = exq[c].pop_front();
                            chk($sformatf("period_ch%0d", c), cnt[c], e.per);
                            chk($sformatf("high_ch%0d", c), hi[c], e.hi);
                        end
                        cnt[c] = 0;
                        hi[c]  = 0;
                    end
                end else begin
                    cnt[c] = 0;
                    hi[c]  = 0;
                end
            end
            if (!bus.cfg_ready) lowrun++;
            else begin
                if (lowrun > 0 && rq.size() > 0) chk("ready_low_cycles", lowrun, rq.pop_front());
                lowrun = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.cfg_ready && n < 2000) begin @(negedge CLK100MHZ); n++; end
        chk("cfg_ready_wait", int'(bus.cfg_ready), 1);
        @(negedge CLK100MHZ);
    endtask

    task automatic cfg(input int ch, input int dv, input bit en);
        int n = 0;
        while (!bus.cfg_ready && n < 2000) begin @(negedge CLK100MHZ); n++; end
        chk("cfg_ready_pre", int'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_div   = 27'(dv);
        bus.cfg_en    = en;
        @(negedge CLK100MHZ);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        int left;
        left = rq.size() + exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size();
        while (left > 0 && n < budget) begin
            @(negedge CLK100MHZ);
            n++;
            left = rq.size() + exq[0].size() + exq[1].size() + exq[2].size() + exq[3].size();
        end
        chk("drain_pending", left, 0);
    endtask

    task automatic wait_tick(input int c);
        int n = 0;
        @(negedge CLK100MHZ);
        while (!bus.ch_tick[c] && n < 2000) begin @(negedge CLK100MHZ); n++; end
        chk($sformatf("tick_seen_ch%0d", c), int'(bus.ch_tick[c]), 1);
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;
        bus.cfg_en    = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK100MHZ);
        chk("rst_ch_clk", int'(bus.ch_clk), 0);
        chk("rst_ch_tick", int'(bus.ch_tick), 0);
        chk("rst_ch_active", int'(bus.ch_active), 0);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
        RST = 1'b0;
        @(negedge CLK100MHZ);

        // ch0 div=2: 50 MHz, disabled target -> ready low 2 cycles
        rq.push_back(2);
        repeat (3) exq[0].push_back('{2, 1});
        cfg(0, 2, 1);
        drain(200);

        // Disable ch0 then re-enable with div=0 (clamped to 2)
        cfg(0, 7, 0);
        wait_ready();
        chk("dis0_active", int'(bus.ch_active[0]), 0);
        chk("dis0_clk", int'(bus.ch_clk[0]), 0);
        rq.push_back(2);
        repeat (2) exq[0].push_back('{2, 1});
        cfg(0, 0, 1);
        drain(200);

        // Again with div=1
        cfg(0, 3, 0);
        wait_ready();
        rq.push_back(2);
        repeat (2) exq[0].push_back('{2, 1});
        cfg(0, 1, 1);
        drain(200);

        // ch1 long divisor
        rq.push_back(2);
        repeat (2) exq[1].push_back('{1000, 500});
        cfg(1, 1000, 1);
        drain(2500);

        // ch2 div=10, then retarget to div=4 while ctr=3
        rq.push_back(2);
        exq[2].push_back('{10, 5});
        cfg(2, 10, 1);
        drain(200);
        wait_tick(2);
        repeat (4) @(negedge CLK100MHZ);   // now in the ctr=3 cycle
        rq.push_back(6);
        exq[2].push_back('{10, 5});
        exq[2].push_back('{4, 2});
        exq[2].push_back('{4, 2});
        cfg(2, 4, 1);
        drain(200);

        // ch3 odd divisor: high phase one cycle longer
        rq.push_back(2);
        repeat (2) exq[3].push_back('{5, 3});
        cfg(3, 5, 1);
        drain(200);

        // Disable ch3 in the ctr=0 cycle: final full period, no runt
        wait_tick(3);
        @(negedge CLK100MHZ);
        rq.push_back(4);
        exq[3].push_back('{5, 3});
        cfg(3, 5, 0);
        drain(200);
        repeat (2) @(negedge CLK100MHZ);
        chk("dis3_active", int'(bus.ch_active[3]), 0);
        chk("dis3_clk", int'(bus.ch_clk[3]), 0);
        chk("dis3_tick", int'(bus.ch_tick[3]), 0);

        // Reset mid-run with a config pending on running ch1
        cfg(1, 8, 1);
        repeat (3) @(negedge CLK100MHZ);
        chk("pend_ready_low", int'(bus.cfg_ready), 0);
        #2 RST = 1'b1;
        #1;
        chk("arst_ch_clk", int'(bus.ch_clk), 0);
        chk("arst_ch_tick", int'(bus.ch_tick), 0);
        chk("arst_ch_active", int'(bus.ch_active), 0);
        chk("arst_cfg_ready", int'(bus.cfg_ready), 1);
        @(negedge CLK100MHZ);
        RST = 1'b0;
        repeat (20) @(negedge CLK100MHZ);
        chk("post_rst_active", int'(bus.ch_active), 0);
        chk("post_rst_ready", int'(bus.cfg_ready), 1);

`ifdef PHASE_SYNC_EN
        rq.push_back(2);
        cfg(0, 6, 1);
        rq.push_back(2);
        cfg(1, 3, 1);
        drain(100);
        repeat (4) @(negedge CLK100MHZ);
        sync_req = 1'b1;
        @(negedge CLK100MHZ);
        sync_req = 1'b0;
        chk("sync_clk_t1", int'(bus.ch_clk[1:0]), 3);
        repeat (5) @(negedge CLK100MHZ);
        chk("sync_clk_t6", int'(bus.ch_clk[1:0]), 0);
        @(negedge CLK100MHZ);
        chk("sync_clk_t7", int'(bus.ch_clk[1:0]), 3);
`endif

        repeat (2) @(negedge CLK100MHZ);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
